// File: rtl/instr_fetch_asm.sv
// Fetch/assemble stage: pairs an even-address word (opcode + target high nibble) with the
// following odd-address word (target low bits), exposes the branch fields to the PC and retires them to decode.

package definitions;
  localparam logic [3:0] kjmp = 4'hA;
endpackage

module instr_fetch_asm #(
  parameter int W    = 9,
  parameter int PCW  = 13,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            init,
  input  logic            halt,
  input  logic [PCW-1:0]  PC,
  input  logic [W-1:0]    imem_rdata,
  output logic [PCW-1:0]  imem_addr,
  output logic [3:0]      OP,
  output logic [3:0]      instr1,
  output logic [W-1:0]    instr2,
  output logic            jump_en,
  output logic [3:0]      dec_op,
  output logic [PCW-1:0]  dec_imm,
  output logic            instr_valid,
  output logic            seq_err,
  output logic [CNTW-1:0] instr_count
);

  typedef enum logic [1:0] {S_HI, S_LO, S_HALT} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [W-1:0]    r_hi;
  logic [3:0]      r_decOp;
  logic [PCW-1:0]  r_decImm;
  logic            r_valid;
  logic            r_seqErr;
  logic [CNTW-1:0] r_count;
  logic            w_capture;
  logic            w_retire;
  logic            w_seqErr;
  logic            w_jump;
  logic            w_unused;

  always_ff @(posedge CLK) begin
    if (init) r_state <= S_HI;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (r_state != S_HALT && halt) begin
      w_nextState = S_HALT;
    end else begin
      case (r_state)
        S_HI:    if (!PC[0]) w_nextState = S_LO;
        S_LO:    if (PC[0])  w_nextState = S_HI;
        default: w_nextState = S_HALT;
      endcase
    end
  end

  // A halt sampled on this edge suppresses capture and retire, and drops the jump request.
  always_comb begin
    w_capture = 1'b0;
    w_retire  = 1'b0;
    w_seqErr  = 1'b0;
    w_jump    = 1'b0;
    case (r_state)
      S_HI: begin
        if (!halt) begin
          if (!PC[0]) w_capture = 1'b1;
          else        w_seqErr  = 1'b1;
        end
      end
      S_LO: begin
        w_jump = (r_hi[8:5] == definitions::kjmp) && !halt;
        if (!halt) begin
          if (PC[0]) begin
            w_retire = 1'b1;
          end else begin
            w_seqErr  = 1'b1;
            w_capture = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (init) begin
      r_hi     <= '0;
      r_decOp  <= '0;
      r_decImm <= '0;
      r_valid  <= 1'b0;
      r_seqErr <= 1'b0;
      r_count  <= '0;
    end else begin
      r_valid <= w_retire;
      if (w_capture) r_hi <= imem_rdata;
      if (w_seqErr)  r_seqErr <= 1'b1;
      if (w_retire) begin
        r_decOp  <= r_hi[8:5];
        r_decImm <= {r_hi[3:0], imem_rdata};
        if (r_count != '1) r_count <= r_count + CNTW'(1);
      end
    end
  end

  // Bit 4 of the even word is reserved and deliberately ignored.
  assign w_unused    = r_hi[4];
  assign imem_addr   = PC;
  assign OP          = r_hi[8:5];
  assign instr1      = r_hi[3:0];
  assign instr2      = imem_rdata;
  assign jump_en     = w_jump;
  assign dec_op      = r_decOp;
  assign dec_imm     = r_decImm;
  assign instr_valid = r_valid;
  assign seq_err     = r_seqErr;
  assign instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch_asm.sv
// Bench for instr_fetch_asm: directed scenarios with literal expectations plus a long random run
// compared every cycle against a pairing model; a CNTW=2 copy exercises counter saturation.

module tb_instr_fetch_asm;

  logic        CLK = 1'b0;
  logic        init = 1'b1;
  logic        halt = 1'b0;
  logic [12:0] PC = '0;
  logic [8:0]  imem_rdata;
  logic [8:0]  mem [8192];

  logic [12:0] imem_addr;
  logic [3:0]  OP;
  logic [3:0]  instr1;
  logic [8:0]  instr2;
  logic        jump_en;
  logic [3:0]  dec_op;
  logic [12:0] dec_imm;
  logic        instr_valid;
  logic        seq_err;
  logic [15:0] instr_count;

  logic [12:0] sImemAddr;
  logic [3:0]  sOp;
  logic [3:0]  sInstr1;
  logic [8:0]  sInstr2;
  logic        sJump;
  logic [3:0]  sDecOp;
  logic [12:0] sDecImm;
  logic        sValid;
  logic        sSeqErr;
  logic [1:0]  sCount;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  assign imem_rdata = mem[PC];

  instr_fetch_asm u_dut (
    .CLK(CLK), .init(init), .halt(halt), .PC(PC), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .OP(OP), .instr1(instr1), .instr2(instr2), .jump_en(jump_en),
    .dec_op(dec_op), .dec_imm(dec_imm), .instr_valid(instr_valid), .seq_err(seq_err),
    .instr_count(instr_count)
  );

  instr_fetch_asm #(.CNTW(2)) u_small (
    .CLK(CLK), .init(init), .halt(halt), .PC(PC), .imem_rdata(imem_rdata),
    .imem_addr(sImemAddr), .OP(sOp), .instr1(sInstr1), .instr2(sInstr2), .jump_en(sJump),
    .dec_op(sDecOp), .dec_imm(sDecImm), .instr_valid(sValid), .seq_err(sSeqErr),
    .instr_count(sCount)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an even word waits for its odd partner; the pair retires when the partner arrives.
  bit          mReady   = 1'b0;
  bit          mPending = 1'b0;
  bit          mHalted  = 1'b0;
  logic [8:0]  mHi      = '0;
  logic [3:0]  mDecOp   = '0;
  logic [12:0] mDecImm  = '0;
  bit          mValid   = 1'b0;
  bit          mErr     = 1'b0;
  int          mCount   = 0;

  always @(posedge CLK) begin
    if (init) begin
      mReady = 1'b1; mPending = 1'b0; mHalted = 1'b0; mHi = '0;
      mDecOp = '0; mDecImm = '0; mValid = 1'b0; mErr = 1'b0; mCount = 0;
    end else if (mReady) begin
      mValid = 1'b0;
      if (mHalted || halt) begin
        mHalted = 1'b1;
      end else if (!mPending) begin
        if (PC % 2 == 0) begin
          mHi = mem[PC];
          mPending = 1'b1;
        end else begin
          mErr = 1'b1;
        end
      end else if (PC % 2 == 1) begin
        mDecOp  = mHi[8:5];
        mDecImm = {mHi[3:0], mem[PC]};
        mValid  = 1'b1;
        mCount++;
        mPending = 1'b0;
      end else begin
        mErr = 1'b1;
        mHi  = mem[PC];
      end
    end
  end

  always @(negedge CLK) begin
    if (mReady) begin
      checkOutput("imem_addr", imem_addr, PC);
      checkOutput("OP", OP, mHi[8:5]);
      checkOutput("instr1", instr1, mHi[3:0]);
      checkOutput("instr2", instr2, mem[PC]);
      checkOutput("jump_en", jump_en,
                  mPending && !mHalted && !halt && (mHi[8:5] == definitions::kjmp));
      checkOutput("dec_op", dec_op, mDecOp);
      checkOutput("dec_imm", dec_imm, mDecImm);
      checkOutput("instr_valid", instr_valid, mValid);
      checkOutput("seq_err", seq_err, mErr);
      checkOutput("instr_count", instr_count, (mCount > 65535) ? 65535 : mCount);
      checkOutput("small_count", sCount, (mCount > 3) ? 3 : mCount);
      checkOutput("small_valid", sValid, mValid);
    end
  end

  task automatic applyStimulus(input bit i, input bit h, input logic [12:0] pc);
    init = i;
    halt = h;
    PC   = pc;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input bit i, input bit h, input logic [12:0] pc);
    applyStimulus(i, h, pc);
    step();
  endtask

  initial begin
    bit          stimHalted;
    logic [12:0] pc;
    int          r;

    for (int a = 0; a < 8192; a++) begin
      mem[a] = 9'($urandom);
      if (a % 2 == 0 && $urandom_range(3) == 0) mem[a][8:5] = definitions::kjmp;
    end
    mem[0]  = 9'b0001_0_0101;
    mem[1]  = 9'h0AB;
    mem[10] = {definitions::kjmp, 1'b0, 4'h0};
    mem[11] = 9'h020;
    mem[12] = 9'b0011_1_0010;

    // Reset with halt also high: init must win
    cyc(1, 1, 0);
    checkOutput("rst_dec_op", dec_op, 0);
    checkOutput("rst_dec_imm", dec_imm, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_seq_err", seq_err, 0);
    checkOutput("rst_count", instr_count, 0);

    // Scenario 1: basic pair
    cyc(0, 0, 0);
    applyStimulus(0, 0, 1);
    checkOutput("t1_OP", OP, 1);
    checkOutput("t1_instr1", instr1, 5);
    checkOutput("t1_instr2", instr2, 9'h0AB);
    step();
    checkOutput("t1_dec_op", dec_op, 1);
    checkOutput("t1_dec_imm", dec_imm, 13'hAAB);
    checkOutput("t1_valid", instr_valid, 1);
    checkOutput("t1_count", instr_count, 1);
    cyc(0, 0, 2);
    checkOutput("t1_valid_drop", instr_valid, 0);
    cyc(0, 0, 3);

    // Scenario 2: jump request only during the odd cycle
    applyStimulus(0, 0, 10);
    checkOutput("t2_jump_even", jump_en, 0);
    step();
    applyStimulus(0, 0, 11);
    checkOutput("t2_jump_odd", jump_en, 1);
    checkOutput("t2_instr2", instr2, 9'h020);
    step();
    applyStimulus(0, 0, 12);
    checkOutput("t2_jump_after", jump_en, 0);
    step();
    cyc(0, 0, 13);

    // Scenario 3: parity error is sticky
    cyc(1, 0, 0);
    cyc(0, 0, 5);
    checkOutput("t3_seq_err", seq_err, 1);
    checkOutput("t3_no_valid", instr_valid, 0);
    cyc(0, 0, 6);
    cyc(0, 0, 7);
    checkOutput("t3_valid", instr_valid, 1);
    checkOutput("t3_seq_err_kept", seq_err, 1);
    checkOutput("t3_count", instr_count, 1);

    // Scenario 4: halt freezes, init recovers
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 10);
    applyStimulus(0, 0, 11);
    checkOutput("t4_jump_halted", jump_en, 0);
    step();
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    checkOutput("t4_dec_op", dec_op, 1);
    checkOutput("t4_dec_imm", dec_imm, 13'hAAB);
    checkOutput("t4_count", instr_count, 2);
    checkOutput("t4_valid", instr_valid, 0);
    cyc(1, 0, 0);
    checkOutput("t4_rst_count", instr_count, 0);
    checkOutput("t4_rst_err", seq_err, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    checkOutput("t4_valid_after", instr_valid, 1);
    checkOutput("t4_count_after", instr_count, 1);

    // Scenario 5: init discards a pending even word
    cyc(1, 0, 0);
    cyc(0, 0, 2);
    cyc(1, 0, 3);
    checkOutput("t5_no_valid", instr_valid, 0);
    checkOutput("t5_count", instr_count, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    checkOutput("t5_count_after", instr_count, 1);

    // Scenario 6: small counter saturates while valid keeps pulsing
    cyc(1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      checkOutput("t6_small_valid", sValid, 1);
    end
    checkOutput("t6_small_count", sCount, 3);
    checkOutput("t6_big_count", instr_count, 5);

    // Random run
    cyc(1, 0, 0);
    stimHalted = 1'b0;
    pc = '0;
    for (int n = 0; n < 4000; n++) begin
      bit i;
      bit h;
      r = $urandom_range(0, 299);
      i = (r == 0) || (stimHalted && $urandom_range(7) == 0);
      h = (r >= 1 && r <= 2) || (i && $urandom_range(3) == 0);
      if ($urandom_range(15) == 0) pc = 13'($urandom);
      else                         pc = pc + 13'd1;
      cyc(i, h, pc);
      if (i)      stimHalted = 1'b0;
      else if (h) stimHalted = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
